// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war playfield.
package tug_pkg;

  typedef enum logic {PLAY, HOLD} pf_state_t;

  localparam int NUM_LEDS_DEF    = 9;
  localparam int HOLD_CYCLES_DEF = 4;

  function automatic int center_of(input int num_leds);
    return (num_leds - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_playfield_if.sv
// Press inputs and LED/win outputs between input conditioners, playfield and scoreboard.
interface tug_playfield_if import tug_pkg::*; #(
  parameter int NUM_LEDS = NUM_LEDS_DEF
);
  logic                L;
  logic                R;
  logic                freeze;
  logic [NUM_LEDS-1:0] leds;
  logic                win_left;
  logic                win_right;

  modport master (
    output L, R, freeze,
    input  leds, win_left, win_right
  );

  modport slave (
    input  L, R, freeze,
    output leds, win_left, win_right
  );
endinterface

// File: rtl/tug_hold_timer.sv
// Loadable down-counter; done is high for the single cycle the count sits at 1.
module tug_hold_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == WIDTH'(1));
endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: moves a single lit LED toward the presser, pulses a win
// at the edges, then keeps the bar dark for HOLD_CYCLES before re-centring.
module tug_playfield import tug_pkg::*; #(
  parameter int NUM_LEDS    = NUM_LEDS_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input logic            clk,
  input logic            reset,
  tug_playfield_if.slave pf
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0]       POS_MAX    = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]       CENTER     = PW'(center_of(NUM_LEDS));
  localparam logic [CW-1:0]       HOLD_LOAD  = CW'(HOLD_CYCLES);
  localparam logic [NUM_LEDS-1:0] LEDS_RESET = NUM_LEDS'(1) << CENTER;

  pf_state_t           state_reg, state_next;
  logic [PW-1:0]       pos_reg, pos_next;
  logic [NUM_LEDS-1:0] leds_reg, leds_next;
  logic                win_left_reg, win_left_next;
  logic                win_right_reg, win_right_next;
  logic                timer_load;
  logic                timer_done;
  logic                press_l;
  logic                press_r;

  tug_hold_timer #(
    .WIDTH(CW)
  ) hold_timer (
    .clk       (clk),
    .srst      (reset),
    .load      (timer_load),
    .load_value(HOLD_LOAD),
    .done      (timer_done)
  );

  // Simultaneous presses cancel, so only exclusive presses count.
  assign press_l = pf.L & ~pf.R;
  assign press_r = pf.R & ~pf.L;

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    win_left_next  = 1'b0;
    win_right_next = 1'b0;
    timer_load     = 1'b0;
    case (state_reg)
      PLAY: begin
        if (!pf.freeze) begin
          if (press_l) begin
            if (pos_reg == POS_MAX) begin
              win_left_next = 1'b1;
              timer_load    = 1'b1;
              state_next    = HOLD;
            end else begin
              pos_next = pos_reg + PW'(1);
            end
          end else if (press_r) begin
            if (pos_reg == '0) begin
              win_right_next = 1'b1;
              timer_load     = 1'b1;
              state_next     = HOLD;
            end else begin
              pos_next = pos_reg - PW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (timer_done) begin
          state_next = PLAY;
          pos_next   = CENTER;
        end
      end
      default: begin
        state_next = PLAY;
        pos_next   = CENTER;
      end
    endcase
  end

  // Bar is decoded from the next state so it is registered alongside pos.
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      assign leds_next[gi] = (state_next == PLAY) && (pos_next == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PLAY;
      pos_reg       <= CENTER;
      leds_reg      <= LEDS_RESET;
      win_left_reg  <= 1'b0;
      win_right_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      leds_reg      <= leds_next;
      win_left_reg  <= win_left_next;
      win_right_reg <= win_right_next;
    end
  end

  assign pf.leds      = leds_reg;
  assign pf.win_left  = win_left_reg;
  assign pf.win_right = win_right_reg;
endmodule

// File: tb/tb_tug_playfield.sv
// Scoreboard bench for tug_playfield: stimulus queues hand-computed expectations,
// a monitor pops one per clock and compares against the registered outputs.
module tb_tug_playfield;
  import tug_pkg::*;

  typedef struct {
    logic [8:0] leds;
    logic       wl;
    logic       wr;
    int         phase;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  tug_playfield_if #(.NUM_LEDS(9)) bus ();

  tug_playfield #(
    .NUM_LEDS   (9),
    .HOLD_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pf   (bus)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected after the next posedge.
  task automatic step(input logic l, input logic r, input logic fz, input logic rs,
                      input logic [8:0] el, input logic ewl, input logic ewr,
                      input int ph);
    exp_t e;
    @(negedge clk);
    bus.L      = l;
    bus.R      = r;
    bus.freeze = fz;
    reset      = rs;
    e.leds  = el;
    e.wl    = ewl;
    e.wr    = ewr;
    e.phase = ph;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if (bus.leds !== e.leds || bus.win_left !== e.wl || bus.win_right !== e.wr) begin
          errors++;
          $display("FAIL txn %0d phase %0d outputs: got leds=%b wl=%b wr=%b, want leds=%b wl=%b wr=%b",
                   txn, e.phase, bus.leds, bus.win_left, bus.win_right, e.leds, e.wl, e.wr);
        end else begin
          $display("txn %0d phase %0d leds=%b wl=%b wr=%b ok",
                   txn, e.phase, bus.leds, bus.win_left, bus.win_right);
        end
      end
    end
  end

  initial begin : stimulus
    bus.L      = 1'b0;
    bus.R      = 1'b0;
    bus.freeze = 1'b0;

    // 1: reset to centre
    step(0, 0, 0, 1, 9'b000010000, 0, 0, 1);
    // 2: four L presses, one every other cycle
    step(1, 0, 0, 0, 9'b000100000, 0, 0, 2);
    step(0, 0, 0, 0, 9'b000100000, 0, 0, 2);
    step(1, 0, 0, 0, 9'b001000000, 0, 0, 2);
    step(0, 0, 0, 0, 9'b001000000, 0, 0, 2);
    step(1, 0, 0, 0, 9'b010000000, 0, 0, 2);
    step(0, 0, 0, 0, 9'b010000000, 0, 0, 2);
    step(1, 0, 0, 0, 9'b100000000, 0, 0, 2);
    step(0, 0, 0, 0, 9'b100000000, 0, 0, 2);
    // 3: L at left edge wins; presses during the dark interval are ignored
    step(1, 0, 0, 0, 9'b000000000, 1, 0, 3);
    step(1, 0, 0, 0, 9'b000000000, 0, 0, 3);
    step(0, 1, 0, 0, 9'b000000000, 0, 0, 3);
    step(1, 0, 1, 0, 9'b000000000, 0, 0, 3);
    step(1, 0, 0, 0, 9'b000010000, 0, 0, 3);
    // 4: walk to right edge, L+R does nothing, then R wins
    step(0, 1, 0, 0, 9'b000001000, 0, 0, 4);
    step(0, 1, 0, 0, 9'b000000100, 0, 0, 4);
    step(0, 1, 0, 0, 9'b000000010, 0, 0, 4);
    step(0, 1, 0, 0, 9'b000000001, 0, 0, 4);
    step(1, 1, 0, 0, 9'b000000001, 0, 0, 4);
    step(0, 1, 0, 0, 9'b000000000, 0, 1, 4);
    step(0, 1, 0, 0, 9'b000000000, 0, 0, 4);
    step(0, 0, 0, 0, 9'b000000000, 0, 0, 4);
    step(0, 0, 0, 0, 9'b000000000, 0, 0, 4);
    step(0, 0, 0, 0, 9'b000010000, 0, 0, 4);
    // 5: freeze blocks ten L presses and an R, then one L moves
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 0, 9'b000010000, 0, 0, 5);
    end
    step(0, 1, 1, 0, 9'b000010000, 0, 0, 5);
    step(1, 0, 0, 0, 9'b000100000, 0, 0, 5);
    // 6: reset in the second dark cycle re-centres and play resumes at once
    step(1, 0, 0, 0, 9'b001000000, 0, 0, 6);
    step(1, 0, 0, 0, 9'b010000000, 0, 0, 6);
    step(1, 0, 0, 0, 9'b100000000, 0, 0, 6);
    step(1, 0, 0, 0, 9'b000000000, 1, 0, 6);
    step(0, 0, 0, 1, 9'b000010000, 0, 0, 6);
    step(1, 0, 0, 0, 9'b000100000, 0, 0, 6);
    step(0, 0, 0, 0, 9'b000100000, 0, 0, 6);
    step(0, 0, 0, 0, 9'b000100000, 0, 0, 6);
    step(0, 0, 0, 0, 9'b000100000, 0, 0, 6);
    step(0, 0, 0, 0, 9'b000100000, 0, 0, 6);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
